// File: rtl/inv_key_expansion_if.sv
// Handshake bundle between the inverse key schedule and its host/consumer.
// master drives start/last_key/ready; slave returns the round key stream.
interface inv_key_expansion_if;
  logic         start;
  logic [127:0] last_key;
  logic         ready;
  logic         valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  modport master (
    output start, last_key, ready,
    input  valid, round_key, round_idx, busy, done
  );

  modport slave (
    input  start, last_key, ready,
    output valid, round_key, round_idx, busy, done
  );
endinterface

// File: rtl/inv_key_expansion.sv
// Sequential inverse AES-128 key schedule: emits round keys 10 down to 0 from the round-10 key.
// Optional macro INV_KEYEXP_REGSBOX_EN registers SubWord in an extra STEP state per round.
module inv_key_expansion (
  input logic                clk,
  input logic                reset,
  inv_key_expansion_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_STEP} state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t       r_state;
  state_t       w_next;
  logic [127:0] r_key;
  logic [3:0]   r_idx;
  logic         r_done;
  logic         w_load;
  logic         w_adv;
  logic         w_fin;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_p0, w_p1, w_p2, w_p3;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_sub_sel;

  // Undo one forward step: the upper three words fall out of XORs, word 0 needs the round function.
  assign w_w0  = r_key[127:96];
  assign w_w1  = r_key[95:64];
  assign w_w2  = r_key[63:32];
  assign w_w3  = r_key[31:0];
  assign w_p3  = w_w3 ^ w_w2;
  assign w_p2  = w_w2 ^ w_w1;
  assign w_p1  = w_w1 ^ w_w0;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};
  assign w_sub = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]], SBOX[w_rot[15:8]], SBOX[w_rot[7:0]]};

`ifdef INV_KEYEXP_REGSBOX_EN
  logic        w_sub_en;
  logic [31:0] r_sub;

  always_ff @(posedge clk) begin
    if (w_sub_en) r_sub <= w_sub;
  end

  assign w_sub_sel = r_sub;
`else
  assign w_sub_sel = w_sub;
`endif

  assign w_p0 = w_w0 ^ w_sub_sel ^ {rcon(r_idx), 24'h000000};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_adv  = 1'b0;
    w_fin  = 1'b0;
`ifdef INV_KEYEXP_REGSBOX_EN
    w_sub_en = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.ready) begin
          if (r_idx == 4'd0) begin
            w_fin  = 1'b1;
            w_next = S_IDLE;
          end else begin
`ifdef INV_KEYEXP_REGSBOX_EN
            w_sub_en = 1'b1;
            w_next   = S_STEP;
`else
            w_adv = 1'b1;
`endif
          end
        end
      end
`ifdef INV_KEYEXP_REGSBOX_EN
      S_STEP: begin
        w_adv  = 1'b1;
        w_next = S_EMIT;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Key and index only move on load or advance, so they hold under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key  <= '0;
      r_idx  <= 4'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_load) begin
        r_key <= bus.last_key;
        r_idx <= 4'd10;
      end else if (w_adv) begin
        r_key <= {w_p0, w_p1, w_p2, w_p3};
        r_idx <= r_idx - 4'd1;
      end
    end
  end

  assign bus.valid     = (r_state == S_EMIT);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.round_key = r_key;
  assign bus.round_idx = r_idx;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Bench for inv_key_expansion: word-array reference schedule with a GF(2^8)-derived S-box,
// a per-cycle monitor, and directed plus randomized schedules.
module tb_inv_key_expansion;
  logic clk = 1'b0;
  logic reset = 1'b1;
  inv_key_expansion_if bus();

  inv_key_expansion dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

`ifdef INV_KEYEXP_REGSBOX_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  localparam logic [127:0] FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [0:255];
  bit rdy_mode = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [7:0] rc(input int j);
    logic [7:0] r = 8'h01;
    for (int k = 1; k < j; k++) r = xt(r);
    return r;
  endfunction

  // Run the FIPS-197 word recurrence backwards over the 44-word array, then pick round r.
  function automatic logic [127:0] model_key(input logic [127:0] k10, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int j = 0; j < 4; j++) w[40 + j] = k10[127 - 32 * j -: 32];
    for (int i = 43; i >= 4; i--) begin
      t = w[i - 1];
      if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rc(i / 4), 24'h000000};
      w[i - 4] = w[i] ^ t;
    end
    return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endfunction

  // Monitor: checks this cycle's outputs, then predicts the next cycle from the inputs in flight.
  bit           mon_on = 1'b0;
  bit           m_active = 1'b0;
  bit           m_after_reset = 1'b0;
  bit           m_done_next = 1'b0;
  bit           m_hold = 1'b0;
  int           m_wait = 0;
  int           m_idx = 0;
  logic [127:0] m_k10 = '0;
  logic [127:0] m_hold_key = '0;
  logic [3:0]   m_hold_idx = '0;
  logic [127:0] got [0:10];

  always @(negedge clk) begin
    if (mon_on) begin
      if (m_after_reset) begin
        chk("rst_valid", 128'(bus.valid), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_done", 128'(bus.done), 128'(0));
        chk("rst_key", bus.round_key, 128'(0));
        chk("rst_idx", 128'(bus.round_idx), 128'(0));
        m_after_reset = 1'b0;
      end
      chk("valid_done_excl", 128'(bus.valid & bus.done), 128'(0));
      chk("done", 128'(bus.done), 128'(m_done_next));
      m_done_next = 1'b0;
      if (m_active && m_wait == 0) begin
        chk("valid", 128'(bus.valid), 128'(1));
        chk("busy", 128'(bus.busy), 128'(1));
        chk("idx", 128'(bus.round_idx), 128'(m_idx));
        chk("key", bus.round_key, model_key(m_k10, m_idx));
        if (m_hold) begin
          chk("hold_key", bus.round_key, m_hold_key);
          chk("hold_idx", 128'(bus.round_idx), 128'(m_hold_idx));
        end
        if (bus.round_idx <= 4'd10) got[bus.round_idx] = bus.round_key;
      end else if (m_active) begin
        chk("step_valid", 128'(bus.valid), 128'(0));
        chk("step_busy", 128'(bus.busy), 128'(1));
      end else begin
        chk("idle_valid", 128'(bus.valid), 128'(0));
        chk("idle_busy", 128'(bus.busy), 128'(0));
      end
      m_hold = m_active && m_wait == 0 && !bus.ready;
      m_hold_key = bus.round_key;
      m_hold_idx = bus.round_idx;
      if (reset) begin
        m_active = 1'b0;
        m_after_reset = 1'b1;
        m_done_next = 1'b0;
        m_hold = 1'b0;
      end else if (!m_active) begin
        if (bus.start) begin
          m_active = 1'b1;
          m_idx = 10;
          m_wait = 0;
          m_k10 = bus.last_key;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (bus.ready) begin
        if (m_idx == 0) begin
          m_active = 1'b0;
          m_done_next = 1'b1;
        end else begin
          m_idx--;
          m_wait = GAP;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // act: 0 none, 1 start with zero key at round stop, 2 reset at round stop.
  task automatic sched(input logic [127:0] k, input int act, input int stop, output int lat);
    int  first = -1;
    bit  seen = 1'b0;
    bit  acted = 1'b0;
    bit  aborted = 1'b0;
    lat = -1;
    for (int j = 0; j <= 10; j++) got[j] = 'x;
    bus.start = 1'b1;
    bus.last_key = k;
    step();
    bus.start = 1'b0;
    bus.last_key = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 300; i++) begin
      if (i > 0) step();
      bus.start = 1'b0;
      reset = 1'b0;
      if (aborted) break;
      if (bus.valid && first < 0) first = i;
      if (bus.done) begin
        seen = 1'b1;
        lat = i - first;
        break;
      end
      if (!acted && bus.valid && bus.round_idx == 4'(stop)) begin
        acted = 1'b1;
        if (act == 1) begin
          bus.start = 1'b1;
          bus.last_key = '0;
        end
        if (act == 2) begin
          reset = 1'b1;
          aborted = 1'b1;
        end
      end
    end
    if (act != 2) begin
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL sched_timeout actual=no_done required=done");
      end
    end
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ref_keys [0:10];
    int lat;
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
    end
    bus.start = 1'b0;
    bus.last_key = '0;
    bus.ready = 1'b1;

    chk("model_fips_r0", model_key(FIPS10, 0), FIPS0);
    chk("model_fips_r9", model_key(FIPS10, 9), FIPS9);
    chk("model_zero_r0", model_key(ZERO10, 0), 128'(0));

    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    step();
    reset = 1'b0;
    step();

    // FIPS-197 vector with ready held high.
    rdy_mode = 1'b0;
    step();
    sched(FIPS10, 0, 0, lat);
    chk("fips_r10", got[10], FIPS10);
    chk("fips_r9", got[9], FIPS9);
    chk("fips_r1", got[1], FIPS1);
    chk("fips_r0", got[0], FIPS0);
    chk("done_latency", 128'(lat), 128'(11 + 10 * GAP));
    chk("busy_after", 128'(bus.busy), 128'(0));
    for (int j = 0; j <= 10; j++) ref_keys[j] = got[j];

    // Random backpressure, same vector.
    rdy_mode = 1'b1;
    sched(FIPS10, 0, 0, lat);
    for (int j = 0; j <= 10; j++) chk($sformatf("bp_r%0d", j), got[j], ref_keys[j]);

    // Start while busy must be ignored.
    rdy_mode = 1'b0;
    step();
    sched(FIPS10, 1, 7, lat);
    chk("ignore_start_r0", got[0], FIPS0);

    // Reset in the middle, then a fresh schedule.
    sched(FIPS10, 2, 5, lat);
    step();
    chk("abort_busy", 128'(bus.busy), 128'(0));
    sched(FIPS10, 0, 0, lat);
    chk("after_reset_r10", got[10], FIPS10);
    chk("after_reset_r0", got[0], FIPS0);

    // Round 10 of the all-zero key unwinds to zero.
    sched(ZERO10, 0, 0, lat);
    chk("zero_r0", got[0], 128'(0));

    // Random keys under random backpressure, checked by the monitor each cycle.
    rdy_mode = 1'b1;
    for (int n = 0; n < 4; n++) begin
      sched({$urandom, $urandom, $urandom, $urandom}, 0, 0, lat);
    end
    rdy_mode = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inv_key_expansion.md
Name: inv_key_expansion

Overview:
- Sequential inverse AES-128 key schedule for the decryption datapath.
- Takes the final (round-10) round key and produces round keys 10, 9, …, 0, one per valid/ready handshake, in the order the inverse cipher consumes them.
- Sits between the key register and the inverse round datapath. It is the reverse-direction counterpart of the forward key expansion.

Parameters:
- None. AES-128 is fixed: 128-bit key, 10 rounds.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a schedule from last_key.
- last_key  input  128  round-10 key, sampled only in the cycle start is accepted.
- ready  input  1  consumer accepts the current round_key.
- valid  output  1  round_key and round_idx are valid.
- round_key  output  128  current round key, word 0 in bits [127:96].
- round_idx  output  4  round number of round_key, 10 down to 0.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after round 0 is accepted.

Behaviour:
- Reset (sync, active-high, overrides everything):
  - State goes to IDLE.
  - valid=0, busy=0, done=0, round_key=0, round_idx=0.
  - Reset mid-schedule aborts it immediately; no done pulse is produced.
- States:
  - IDLE: valid=0, busy=0. start=1 → load round_key<=last_key, round_idx<=10, go to EMIT.
  - EMIT: valid=1, busy=1.
    - ready=1 and round_idx>0 → register the previous round key, round_idx<=round_idx-1, stay in EMIT.
    - ready=1 and round_idx==0 → go to IDLE, done=1 for exactly one cycle, busy drops in that same cycle.
    - ready=0 → hold round_key and round_idx stable.
- Latency:
  - start accepted at edge t → valid=1 with round 10 in the following cycle.
  - Handshake at edge t → next round key valid in the following cycle, giving one round key per cycle when ready is held high.
  - 11 handshakes per schedule.
- Inverse recurrence:
  - Current key is words w0..w3 for round i; previous key is p0..p3.
  - p3=w3^w2; p2=w2^w1; p1=w1^w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon(i).
  - RotWord rotates bytes left by one: {b1,b2,b3,b0}.
  - SubWord is the forward AES S-box applied to each of the 4 bytes. The S-box is a local combinational table.
  - Rcon(i) is placed in the top byte, the low 24 bits are 0: i=1..8 → 01,02,04,08,10,20,40,80; i=9 → 1b; i=10 → 36.
- Boundaries:
  - start while busy is ignored.
  - ready while valid=0 is ignored.
  - start and reset in the same cycle → reset wins.
  - round_idx never wraps below 0.
  - done and valid are never both high.

Optional Feature:
- Macro: INV_KEYEXP_REGSBOX_EN.
- Defined:
  - Adds state STEP. A handshake in EMIT with round_idx>0 goes to STEP, where valid=0 and busy=1.
  - The SubWord result of p3 is registered in STEP. The new key is written at the end of STEP and the block returns to EMIT.
  - Each round key therefore arrives 2 cycles after its handshake.
  - The round-10 latency from start is unchanged.
- Undefined: single-cycle stepping as specified above.

Test Plan:
- FIPS-197 vector:
  - Stimulus: reset, then start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, ready held at 1.
  - Required: 11 consecutive valid cycles. Round 10 = last_key; round 9 = ac7766f319fadc2128d12941575c006e; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - done pulses one cycle after round 0, busy=0 afterwards.
- Backpressure:
  - Stimulus: same vector, ready toggled at random.
  - Required: round_key and round_idx are stable while valid&!ready, and the key sequence is identical to the first test.
- Start while busy:
  - Stimulus: during round 7, assert start with last_key=0.
  - Required: ignored; the sequence continues to 2b7e…4f3c.
- Reset mid-operation:
  - Stimulus: reset at round_idx=5.
  - Required: next cycle valid=0, busy=0, round_key=0; no done pulse.
  - A new start then produces a correct schedule from round 10.
- All-zero key:
  - Stimulus: start with last_key=b4ef5bcb3e92e21123e951cf6f8f188e (round 10 of the all-zero key).
  - Required: round 0 = 00000000000000000000000000000000.
- With INV_KEYEXP_REGSBOX_EN, ready=1:
  - Required: valid follows the pattern 1,0,1,0,… with the same 11 keys as the FIPS-197 test.
  - done occurs 21 cycles after the first valid.
